// File: rtl/wb_pkg.sv
// Shared encodings for the writeback select stage: load sizes, fixed
// source indices and the buffer state type.
package wb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_FULL = 2'd3;

    localparam int SRC_ALU = 0;
    localparam int SRC_MEM = 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fifo_state_t;

endpackage

// File: rtl/wb_load_ext.sv
// Load lane extraction: picks the byte/half/word at a byte offset of the
// memory word and sign- or zero-extends it. Purely combinational.
module wb_load_ext
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        size,
    input  logic              sgn,
    input  logic [2:0]        off,
    output logic [DATA_W-1:0] data,
    output logic              misaligned
);

    logic [1:0]        eff_size;
    logic [DATA_W-1:0] shifted;

    // Shift the addressed lane down to bit 0, then extend by size.
    always_comb begin
        eff_size = size;
        if (DATA_W == 32 && size == SZ_FULL) begin
            eff_size = SZ_WORD;
        end
        shifted    = word >> {off, 3'b000};
        data       = '0;
        misaligned = 1'b0;
        case (eff_size)
            SZ_BYTE: begin
                data = sgn ? DATA_W'($signed(shifted[7:0])) : DATA_W'(shifted[7:0]);
            end
            SZ_HALF: begin
                misaligned = off[0];
                data = sgn ? DATA_W'($signed(shifted[15:0])) : DATA_W'(shifted[15:0]);
            end
            SZ_WORD: begin
                // A 32-bit word has no upper half to address.
                misaligned = (off[1:0] != 2'd0) || (DATA_W == 32 && off[2]);
                data = sgn ? DATA_W'($signed(shifted[31:0])) : DATA_W'(shifted[31:0]);
            end
            default: begin
                misaligned = (off != 3'd0);
                data       = shifted;
            end
        endcase
    end

endmodule

// File: rtl/wb_select_stage.sv
// Writeback select stage: picks one of NUM_SRC result sources, optionally
// extracts/extends a load lane, and buffers beats in a 2-entry FIFO.
// Optional load extraction is enabled by defining WB_LOAD_EXT_EN.
//
// state    | meaning
// ST_EMPTY | no beat buffered, out_valid low
// ST_ONE   | head valid, room for one more
// ST_FULL  | head and tail valid, in_ready low
module wb_select_stage
    import wb_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int NUM_SRC = 4,
    parameter  int REG_AW  = 5,
    localparam int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_SRC*DATA_W-1:0] in_src,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic [1:0]                in_size,
    input  logic                      in_signed,
    input  logic [2:0]                in_off,
    input  logic [REG_AW-1:0]         in_rd,
    input  logic                      in_we,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [REG_AW-1:0]         out_rd,
    output logic                      out_we,
    output logic                      err_sticky
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [REG_AW-1:0] rd;
        logic              we;
    } beat_t;

    fifo_state_t       state, state_nx;
    beat_t             head, tail, beat_nx;
    logic              push, pop, ld_head, ld_tail, shift;
    logic [DATA_W-1:0] sel_data, ext_data;
    logic              sel_ok, is_mem, ext_mis, beat_err;

    assign in_ready   = (state != ST_FULL);
    assign out_valid  = (state != ST_EMPTY);
    assign out_data   = head.data;
    assign out_rd     = head.rd;
    assign out_we     = head.we;
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign is_mem     = (in_sel == SEL_W'(SRC_MEM));

`ifdef WB_LOAD_EXT_EN
    wb_load_ext #(.DATA_W(DATA_W)) u_load_ext (
        .word       (in_src[SRC_MEM*DATA_W +: DATA_W]),
        .size       (in_size),
        .sgn        (in_signed),
        .off        (in_off),
        .data       (ext_data),
        .misaligned (ext_mis)
    );
`else
    wire unused_load_cfg = ^{in_size, in_signed, in_off};
    assign ext_data = in_src[SRC_MEM*DATA_W +: DATA_W];
    assign ext_mis  = 1'b0;
`endif

    // Source mux; an out-of-range select leaves sel_ok low.
    always_comb begin
        sel_data = '0;
        sel_ok   = 1'b0;
        for (int k = SRC_ALU; k < NUM_SRC; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_data = in_src[k*DATA_W +: DATA_W];
                sel_ok   = 1'b1;
            end
        end
    end

    // Form the beat to store; errors store a harmless zero non-write.
    always_comb begin
        beat_err     = !sel_ok || (is_mem && ext_mis);
        beat_nx.data = is_mem ? ext_data : sel_data;
        beat_nx.rd   = in_rd;
        beat_nx.we   = in_we;
        if (beat_err) begin
            beat_nx.data = '0;
            beat_nx.we   = 1'b0;
        end
    end

    // Next-state and storage-control decode; flush overrides everything.
    always_comb begin
        state_nx = state;
        ld_head  = 1'b0;
        ld_tail  = 1'b0;
        shift    = 1'b0;
        if (flush) begin
            state_nx = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        state_nx = ST_ONE;
                        ld_head  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        ld_head = 1'b1;
                    end else if (push) begin
                        state_nx = ST_FULL;
                        ld_tail  = 1'b1;
                    end else if (pop) begin
                        state_nx = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_nx = ST_ONE;
                        shift    = 1'b1;
                    end
                end
                default: state_nx = ST_EMPTY;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // Entry storage: head is what the consumer sees, tail waits behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (ld_head) begin
                head <= beat_nx;
            end else if (shift) begin
                head <= tail;
            end
            if (ld_tail) begin
                tail <= beat_nx;
            end
        end
    end

    // Error flag latches on any accepted erroneous beat; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (push && !flush && beat_err) begin
            err_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage: scoreboard of expected beats plus per-scenario
// inline checks. Expectations follow WB_LOAD_EXT_EN when it is defined.
module tb_wb_select_stage;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_src = '0;
    logic [1:0]   in_sel = '0;
    logic [1:0]   in_size = '0;
    logic         in_signed = 1'b0;
    logic [2:0]   in_off = '0;
    logic [4:0]   in_rd = '0;
    logic         in_we = 1'b0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
    logic [4:0]   out_rd;
    logic         out_we;
    logic         err_sticky;

    // second instance with a non-power-of-two source count
    logic         in5_valid = 1'b0;
    logic         in5_ready;
    logic [159:0] in5_src = '0;
    logic [2:0]   in5_sel = '0;
    logic         out5_valid;
    logic [31:0]  out5_data;
    logic [4:0]   out5_rd;
    logic         out5_we;
    logic         err5_sticky;

    int tests_run = 0;
    int tests_failed = 0;
    int pops = 0;

    logic [37:0] sb_q[$];
    logic [31:0] exp_data;
    logic [4:0]  exp_rd;
    logic        exp_we;

    always #5 clk = ~clk;

    wb_select_stage u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_src(in_src), .in_sel(in_sel), .in_size(in_size), .in_signed(in_signed),
        .in_off(in_off), .in_rd(in_rd), .in_we(in_we), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_we(out_we), .err_sticky(err_sticky)
    );

    wb_select_stage #(.DATA_W(32), .NUM_SRC(5), .REG_AW(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in5_valid), .in_ready(in5_ready),
        .in_src(in5_src), .in_sel(in5_sel), .in_size(2'd2), .in_signed(1'b0),
        .in_off(3'd0), .in_rd(5'd9), .in_we(1'b1), .flush(1'b0),
        .out_valid(out5_valid), .out_ready(1'b1), .out_data(out5_data),
        .out_rd(out5_rd), .out_we(out5_we), .err_sticky(err5_sticky)
    );

    // Independent byte-level model of the load lane.
    function automatic logic [31:0] model_mem(input logic [31:0] mem, input logic [1:0] size,
                                              input logic sgn, input logic [2:0] off,
                                              output logic err);
        logic [7:0]  b [4];
        logic [31:0] v;
        int nb;
        for (int i = 0; i < 4; i++) b[i] = mem[8*i +: 8];
        nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = ((int'(off) % nb) != 0) || (nb == 4 && int'(off) >= 4);
        v = '0;
        for (int i = 0; i < nb; i++) begin
            if (int'(off) + i < 4) v[8*i +: 8] = b[int'(off) + i];
        end
        if (sgn && nb < 4 && v[8*nb-1]) begin
            for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
        end
        return err ? 32'd0 : v;
    endfunction

    task automatic drive_beat(input logic [31:0] s0, input logic [31:0] s1,
                              input logic [31:0] s2, input logic [31:0] s3,
                              input logic [1:0] sel, input logic [1:0] size,
                              input logic sgn, input logic [2:0] off,
                              input logic [4:0] rd, input logic we);
        logic err;
        logic [31:0] d;
        in_src    = {s3, s2, s1, s0};
        in_sel    = sel;
        in_size   = size;
        in_signed = sgn;
        in_off    = off;
        in_rd     = rd;
        in_we     = we;
        err       = 1'b0;
        case (sel)
            2'd0: d = s0;
            2'd1: d = s1;
            2'd2: d = s2;
            default: d = s3;
        endcase
`ifdef WB_LOAD_EXT_EN
        if (sel == 2'd1) d = model_mem(s1, size, sgn, off, err);
`endif
        exp_data = d;
        exp_rd   = rd;
        exp_we   = err ? 1'b0 : we;
        in_valid = 1'b1;
    endtask

    // Scoreboard: pop/compare on handshake out, push expected on accept.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                tests_run++;
                pops++;
                if (sb_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_unexpected: got data=%h rd=%0d we=%0b, required no output",
                             out_data, out_rd, out_we);
                end else begin
                    logic [37:0] e;
                    e = sb_q.pop_front();
                    if ({out_data, out_rd, out_we} !== e) begin
                        tests_failed++;
                        $display("FAIL sb_beat: got data=%h rd=%0d we=%0b, required data=%h rd=%0d we=%0b",
                                 out_data, out_rd, out_we, e[37:6], e[5:1], e[0]);
                    end
                end
            end
            if (in_valid && in_ready) sb_q.push_back({exp_data, exp_rd, exp_we});
        end
    end

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++;
        if (sb_q.size() != 0 || out_valid) begin
            tests_failed++;
            $display("FAIL %s_drain: %0d beats still pending, required 0", name, sb_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({out_valid, out_data, out_rd, out_we, err_sticky} !== 40'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got valid=%0b data=%h rd=%0d we=%0b err=%0b, required all 0",
                     out_valid, out_data, out_rd, out_we, err_sticky);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
        end
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        drive_beat(32'h1234_5678, 32'h0, 32'h0, 32'h0, 2'd0, 2'd2, 1'b0, 3'd0, 5'd3, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL latency: got valid=%0b data=%h, required valid=1 data=12345678",
                     out_valid, out_data);
        end
        wait_drain("latency");
    endtask

    task automatic test_load_ext();
        logic [1:0]  sz  [7] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3};
        logic        sg  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [2:0]  of  [7] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd2, 3'd0, 3'd0};
`ifdef WB_LOAD_EXT_EN
        logic [31:0] req [7] = '{32'hFFFF_FF80, 32'h0000_8040, 32'hFFFF_FFC0, 32'h8040_C0FF,
                                 32'hFFFF_8040, 32'h0000_00FF, 32'h8040_C0FF};
`else
        logic [31:0] req [7] = '{32'h8040_C0FF, 32'h8040_C0FF, 32'h8040_C0FF, 32'h8040_C0FF,
                                 32'h8040_C0FF, 32'h8040_C0FF, 32'h8040_C0FF};
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive_beat(32'h1111_1111, 32'h8040_C0FF, 32'h2222_2222, 32'h3333_3333,
                       2'd1, sz[i], sg[i], of[i], 5'(i + 1), 1'b1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            tests_run++;
            if (out_data !== req[i]) begin
                tests_failed++;
                $display("FAIL load_ext_%0d: got %h, required %h", i, out_data, req[i]);
            end
        end
        wait_drain("load_ext");
        tests_run++;
        if (err_sticky !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_ext_err: got err_sticky=%0b, required 0", err_sticky);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        out_ready = 1'b1;
        p0 = pops;
        for (int i = 0; i < 8; i++) begin
            tests_run++;
            if (in_ready !== 1'b1 || (i > 0 && out_valid !== 1'b1)) begin
                tests_failed++;
                $display("FAIL b2b_flow_%0d: got in_ready=%0b out_valid=%0b, required 1/1",
                         i, in_ready, out_valid);
            end
            drive_beat($urandom, $urandom, $urandom, $urandom, 2'(i), 2'd2, 1'b0, 3'd0,
                       5'(i + 10), i[0]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (pops - p0 != 8) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d beats out, required 8", pops - p0);
        end
        wait_drain("b2b");
    endtask

    task automatic test_backpressure();
        logic [31:0] a_data;
        logic        accepted;
        int          p0;
        p0 = pops;
        out_ready = 1'b0;
        a_data = 32'hAAAA_0001;
        drive_beat(a_data, 32'h0, 32'h0, 32'h0, 2'd0, 2'd2, 1'b0, 3'd0, 5'd1, 1'b1);
        @(posedge clk); #1;
        drive_beat(32'hBBBB_0002, 32'h0, 32'h0, 32'h0, 2'd0, 2'd2, 1'b0, 3'd0, 5'd2, 1'b1);
        @(posedge clk); #1;
        drive_beat(32'h0, 32'h0, 32'hCCCC_0003, 32'h0, 2'd2, 2'd2, 1'b0, 3'd0, 5'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== a_data) begin
                tests_failed++;
                $display("FAIL bp_hold_%0d: got in_ready=%0b valid=%0b data=%h, required 0/1/%h",
                         i, in_ready, out_valid, out_data, a_data);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        accepted = 1'b0;
        for (int n = 0; n < 10 && !accepted; n++) begin
            if (in_ready) accepted = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        tests_run++;
        if (!accepted) begin
            tests_failed++;
            $display("FAIL bp_accept_c: got no accept within 10 cycles, required accept");
        end
        wait_drain("bp");
        tests_run++;
        if (pops - p0 != 3) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d beats out, required 3", pops - p0);
        end
    endtask

    task automatic test_errors();
        out_ready = 1'b1;
        drive_beat(32'h0, 32'h8040_C0FF, 32'h0, 32'h0, 2'd1, 2'd1, 1'b0, 3'd1, 5'd7, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests_run++;
`ifdef WB_LOAD_EXT_EN
        if (out_we !== 1'b0 || out_data !== 32'd0 || err_sticky !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_misaligned: got we=%0b data=%h err=%0b, required 0/0/1",
                     out_we, out_data, err_sticky);
        end
`else
        if (out_we !== 1'b1 || out_data !== 32'h8040_C0FF || err_sticky !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_passthru: got we=%0b data=%h err=%0b, required 1/8040c0ff/0",
                     out_we, out_data, err_sticky);
        end
`endif
        wait_drain("err");
        // sticky flag survives good traffic
        drive_beat(32'h5555_5555, 32'h0, 32'h0, 32'h0, 2'd0, 2'd2, 1'b0, 3'd0, 5'd8, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain("err_after");
        tests_run++;
`ifdef WB_LOAD_EXT_EN
        if (err_sticky !== 1'b1) begin
`else
        if (err_sticky !== 1'b0) begin
`endif
            tests_failed++;
            $display("FAIL err_sticky_hold: got %0b, required opposite", err_sticky);
        end
        // five-source instance: last legal source, then illegal select
        in5_src   = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0};
        in5_sel   = 3'd4;
        in5_valid = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (out5_valid !== 1'b1 || out5_data !== 32'h4444_4444 || out5_we !== 1'b1 ||
            out5_rd !== 5'd9 || err5_sticky !== 1'b0) begin
            tests_failed++;
            $display("FAIL sel4: got valid=%0b data=%h we=%0b rd=%0d err=%0b, required 1/44444444/1/9/0",
                     out5_valid, out5_data, out5_we, out5_rd, err5_sticky);
        end
        in5_sel = 3'd5;
        @(posedge clk); #1;
        in5_valid = 1'b0;
        tests_run++;
        if (out5_valid !== 1'b1 || out5_data !== 32'd0 || out5_we !== 1'b0 || err5_sticky !== 1'b1) begin
            tests_failed++;
            $display("FAIL sel5_err: got valid=%0b data=%h we=%0b err=%0b, required 1/0/0/1",
                     out5_valid, out5_data, out5_we, err5_sticky);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive_beat(32'hF000_0001, 32'h0, 32'h0, 32'h0, 2'd0, 2'd2, 1'b0, 3'd0, 5'd1, 1'b1);
        @(posedge clk); #1;
        drive_beat(32'hF000_0002, 32'h0, 32'h0, 32'h0, 2'd0, 2'd2, 1'b0, 3'd0, 5'd2, 1'b1);
        @(posedge clk); #1;
        drive_beat(32'hF000_0003, 32'h0, 32'h0, 32'h0, 2'd0, 2'd2, 1'b0, 3'd0, 5'd3, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_full: got valid=%0b in_ready=%0b, required 0/1", out_valid, in_ready);
        end
        // one buffered beat plus a beat pushed in the flush cycle
        drive_beat(32'hF000_0004, 32'h0, 32'h0, 32'h0, 2'd0, 2'd2, 1'b0, 3'd0, 5'd4, 1'b1);
        @(posedge clk); #1;
        drive_beat(32'hF000_0005, 32'h0, 32'h0, 32'h0, 2'd0, 2'd2, 1'b0, 3'd0, 5'd5, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL flush_stale_%0d: got valid=%0b data=%h, required valid=0",
                         i, out_valid, out_data);
            end
            @(posedge clk); #1;
        end
        drive_beat(32'hF000_0006, 32'h0, 32'h0, 32'h0, 2'd0, 2'd2, 1'b0, 3'd0, 5'd6, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain("flush");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive_beat(32'hD000_0001, 32'h0, 32'h0, 32'h0, 2'd0, 2'd2, 1'b0, 3'd0, 5'd1, 1'b1);
        @(posedge clk); #1;
        drive_beat(32'hD000_0002, 32'h0, 32'h0, 32'h0, 2'd0, 2'd2, 1'b0, 3'd0, 5'd2, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || err_sticky !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_async: got valid=%0b data=%h err=%0b, required 0/0/0",
                     out_valid, out_data, err_sticky);
        end
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_mid_leak_%0d: got valid=%0b, required 0", i, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_load_ext();
        test_back_to_back();
        test_backpressure();
        test_errors();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
